// File: rtl/login_ctrl.sv
// Login sequencer: gates ID entry, scans the registered ID table, grants a session or denies.
// Optional lockout after repeated failures is built when LOGIN_CTRL_LOCKOUT_EN is defined.
module login_ctrl #(
   parameter int          NUM_USERS   = 4,
   parameter logic [15:0] USER_ID0    = 16'h1234,
   parameter logic [15:0] USER_ID1    = 16'h5678,
   parameter logic [15:0] USER_ID2    = 16'h9ABC,
   parameter logic [15:0] USER_ID3    = 16'h0F0F,
   parameter int          MAX_FAILS   = 3,
   parameter logic [15:0] LOCK_CYCLES = 16'd50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        logout,
   input  logic        id_valid,
   input  logic [15:0] id_in,
   output logic        entry_auth,
   output logic        entry_rst_n,
   output logic        session_active,
   output logic [1:0]  user_index,
   output logic        deny,
   output logic        locked,
   output logic [1:0]  fail_count
);

   // state | meaning
   // IDLE  | no session, ID-entry block held in restart
   // ENTRY | digit entry enabled, waiting for a complete ID
   // CHECK | scanning the ID table, one entry per cycle
   // GRANT | session open for user_index
   // DENY  | one-cycle reject pulse, ID-entry restarted
   // LOCK  | lockout timer running (lockout build only)
`ifdef LOGIN_CTRL_LOCKOUT_EN
   typedef enum logic [2:0] {IDLE, ENTRY, CHECK, GRANT, DENY, LOCK} state_t;
   localparam logic [1:0] MAX_F = 2'(MAX_FAILS);
   logic [15:0] lock_cnt;
`else
   typedef enum logic [2:0] {IDLE, ENTRY, CHECK, GRANT, DENY} state_t;
   logic unused_cfg;
   assign unused_cfg = ^{LOCK_CYCLES, 32'(MAX_FAILS)};
`endif

   localparam logic [1:0] LAST_IDX = 2'(NUM_USERS - 1);

   state_t      state, state_nxt;
   logic [1:0]  scan_idx;
   logic [15:0] id_latch;
   logic [15:0] cur_id;
   logic        match;
   logic [1:0]  fail_inc;

   always_comb begin
      case (scan_idx)
         2'd0:    cur_id = USER_ID0;
         2'd1:    cur_id = USER_ID1;
         2'd2:    cur_id = USER_ID2;
         default: cur_id = USER_ID3;
      endcase
   end

   assign match    = (id_latch == cur_id);
   assign fail_inc = (fail_count == 2'd3) ? 2'd3 : fail_count + 2'd1;

   always_comb begin
      state_nxt      = state;
      entry_auth     = 1'b0;
      entry_rst_n    = 1'b0;
      session_active = 1'b0;
      deny           = 1'b0;
      locked         = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = ENTRY;
         end
         ENTRY: begin
            entry_auth  = 1'b1;
            entry_rst_n = 1'b1;
            if (logout)        state_nxt = IDLE;
            else if (id_valid) state_nxt = CHECK;
         end
         CHECK: begin
            // entry block keeps its digits while the scan runs
            entry_rst_n = 1'b1;
            if (match)                      state_nxt = GRANT;
            else if (scan_idx == LAST_IDX)  state_nxt = DENY;
         end
         GRANT: begin
            session_active = 1'b1;
            if (logout) state_nxt = IDLE;
         end
         DENY: begin
            deny      = 1'b1;
            state_nxt = ENTRY;
`ifdef LOGIN_CTRL_LOCKOUT_EN
            if (fail_count == MAX_F) state_nxt = LOCK;
`endif
         end
`ifdef LOGIN_CTRL_LOCKOUT_EN
         LOCK: begin
            locked = 1'b1;
            if (lock_cnt == 16'd0) state_nxt = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         scan_idx   <= 2'd0;
         id_latch   <= 16'd0;
         user_index <= 2'd0;
         fail_count <= 2'd0;
`ifdef LOGIN_CTRL_LOCKOUT_EN
         lock_cnt   <= 16'd0;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            ENTRY: begin
               if (!logout && id_valid) begin
                  id_latch <= id_in;
                  scan_idx <= 2'd0;
               end
            end
            CHECK: begin
               if (match) begin
                  user_index <= scan_idx;
                  fail_count <= 2'd0;
               end else if (scan_idx == LAST_IDX) begin
                  fail_count <= fail_inc;
               end else begin
                  scan_idx <= scan_idx + 2'd1;
               end
            end
`ifdef LOGIN_CTRL_LOCKOUT_EN
            DENY: begin
               if (fail_count == MAX_F) lock_cnt <= LOCK_CYCLES - 16'd1;
            end
            LOCK: begin
               if (lock_cnt != 16'd0) lock_cnt <= lock_cnt - 16'd1;
               else                   fail_count <= 2'd0;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule
